// File: rtl/snow64_vector_alu_sequencer_if.sv
// Request/response/ALU bundle for the vector ALU sequencer.
// slave  : sequencer view (consumes requests and ALU results, produces ALU operands and results)
// master : environment view (decode/operand read, writeback and the shared ALU)
// Signals:
//   in_valid/out_in_ready       upstream request handshake
//   in_oper, in_unsgn_or_sgn,
//   in_int_type, in_scalar      request control fields
//   in_a, in_b                  vector operands
//   out_alu_*                   chunk operands and control to the shared ALU
//   in_alu_result               combinational ALU result for the current chunk
//   out_valid/in_ready          downstream result handshake
//   out_data                    result buffer
//   out_busy                    sequencer not idle
interface snow64_vector_alu_sequencer_if #(
  parameter int unsigned WIDTH__VECTOR = 256,
  parameter int unsigned WIDTH__CHUNK  = 64
);
  logic                     in_valid;
  logic                     out_in_ready;
  logic [3:0]               in_oper;
  logic                     in_unsgn_or_sgn;
  logic [1:0]               in_int_type;
  logic                     in_scalar;
  logic [WIDTH__VECTOR-1:0] in_a;
  logic [WIDTH__VECTOR-1:0] in_b;
  logic [WIDTH__CHUNK-1:0]  out_alu_a;
  logic [WIDTH__CHUNK-1:0]  out_alu_b;
  logic [3:0]               out_alu_oper;
  logic                     out_alu_unsgn_or_sgn;
  logic [1:0]               out_alu_int_type;
  logic [WIDTH__CHUNK-1:0]  in_alu_result;
  logic                     out_valid;
  logic                     in_ready;
  logic [WIDTH__VECTOR-1:0] out_data;
  logic                     out_busy;

  modport slave (
    input  in_valid, in_oper, in_unsgn_or_sgn, in_int_type, in_scalar, in_a, in_b,
    input  in_alu_result, in_ready,
    output out_in_ready, out_alu_a, out_alu_b, out_alu_oper, out_alu_unsgn_or_sgn,
    output out_alu_int_type, out_valid, out_data, out_busy
  );

  modport master (
    output in_valid, in_oper, in_unsgn_or_sgn, in_int_type, in_scalar, in_a, in_b,
    output in_alu_result, in_ready,
    input  out_in_ready, out_alu_a, out_alu_b, out_alu_oper, out_alu_unsgn_or_sgn,
    input  out_alu_int_type, out_valid, out_data, out_busy
  );
endinterface

// File: rtl/snow64_vector_alu_sequencer.sv
// Vector ALU sequencer: runs one wide vector operation through a single shared
// chunk-wide lane-split ALU, one chunk per cycle, collecting results in a buffer.
// Ports:
//   clk     clock, rising edge
//   rst     synchronous active-high reset
//   bus_io  request, ALU and result signals (see snow64_vector_alu_sequencer_if)
module snow64_vector_alu_sequencer #(
  parameter int unsigned WIDTH__VECTOR = 256,
  parameter int unsigned WIDTH__CHUNK  = 64
) (
  input logic                          clk,
  input logic                          rst,
  snow64_vector_alu_sequencer_if.slave bus_io
);

  localparam int unsigned NUM_CHUNKS = WIDTH__VECTOR / WIDTH__CHUNK;
  localparam int unsigned IdxW       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  typedef logic [NUM_CHUNKS-1:0][WIDTH__CHUNK-1:0] vec_t;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  vec_t            a_q, a_d;
  vec_t            b_q, b_d;
  vec_t            data_q, data_d;
  logic [3:0]      oper_q, oper_d;
  logic            sgn_q, sgn_d;
  logic [1:0]      int_type_q, int_type_d;
  logic            scalar_q, scalar_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      data_q     <= '0;
      oper_q     <= '0;
      sgn_q      <= 1'b0;
      int_type_q <= '0;
      scalar_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      data_q     <= data_d;
      oper_q     <= oper_d;
      sgn_q      <= sgn_d;
      int_type_q <= int_type_d;
      scalar_q   <= scalar_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    data_d     = data_q;
    oper_d     = oper_q;
    sgn_d      = sgn_q;
    int_type_d = int_type_q;
    scalar_d   = scalar_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          a_d        = bus_io.in_a;
          b_d        = bus_io.in_b;
          oper_d     = bus_io.in_oper;
          sgn_d      = bus_io.in_unsgn_or_sgn;
          int_type_d = bus_io.in_int_type;
          scalar_d   = bus_io.in_scalar;
          data_d     = '0;
          idx_d      = '0;
          state_d    = StRun;
        end
      end
      StRun: begin
        data_d[idx_q] = bus_io.in_alu_result;
        // idx stays on the last chunk in DONE so the ALU operands hold still
        if (scalar_q || (idx_q == LastIdx)) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (bus_io.in_ready) begin
          state_d = StIdle;
          idx_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Ready depends on state only, so DONE never accepts in the same cycle.
  assign bus_io.out_in_ready         = (state_q == StIdle);
  assign bus_io.out_valid            = (state_q == StDone);
  assign bus_io.out_busy             = (state_q != StIdle);
  assign bus_io.out_data             = data_q;
  assign bus_io.out_alu_a            = a_q[idx_q];
  assign bus_io.out_alu_b            = b_q[idx_q];
  assign bus_io.out_alu_oper         = oper_q;
  assign bus_io.out_alu_unsgn_or_sgn = sgn_q;
  assign bus_io.out_alu_int_type     = int_type_q;

endmodule

// File: tb/tb_snow64_vector_alu_sequencer.sv
module tb_snow64_vector_alu_sequencer;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpSlt = 4'd2;
  localparam logic [3:0] OpAnd = 4'd3;
  localparam logic [3:0] OpOr  = 4'd4;
  localparam logic [3:0] OpXor = 4'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  snow64_vector_alu_sequencer_if #(.WIDTH__VECTOR(256), .WIDTH__CHUNK(64)) ifc ();

  snow64_vector_alu_sequencer #(.WIDTH__VECTOR(256), .WIDTH__CHUNK(64)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (ifc.slave)
  );

  // One lane of the lane-split ALU; lanes are w bits wide, held in the low bits.
  function automatic logic [63:0] lane_op(input logic [3:0] op, input logic sgn,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input int w);
    logic [63:0] mask, sa, sb, r;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a = a & mask;
    b = b & mask;
    sa = a << (64 - w);
    sb = b << (64 - w);
    case (op)
      OpAdd:   r = a + b;
      OpSub:   r = a - b;
      OpSlt:   r = sgn ? {63'd0, $signed(sa) < $signed(sb)} : {63'd0, sa < sb};
      OpAnd:   r = a & b;
      OpOr:    r = a | b;
      OpXor:   r = a ^ b;
      default: r = 64'd0;
    endcase
    return r & mask;
  endfunction

  function automatic logic [63:0] alu_chunk(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] op, input logic sgn,
                                            input logic [1:0] ty);
    int w;
    logic [63:0] r;
    w = 8 << ty;
    r = '0;
    for (int l = 0; l < 64 / w; l++)
      r |= lane_op(op, sgn, a >> (l * w), b >> (l * w), w) << (l * w);
    return r;
  endfunction

  // Whole-vector reference: every lane of the vector (or of the low 64 bits when scalar).
  function automatic logic [255:0] exp_result(input logic [255:0] a, input logic [255:0] b,
                                              input logic [3:0] op, input logic sgn,
                                              input logic [1:0] ty, input logic sc);
    int w, nbits;
    logic [255:0] r;
    logic [63:0] la, lb;
    w = 8 << ty;
    nbits = sc ? 64 : 256;
    r = '0;
    for (int l = 0; l < nbits / w; l++) begin
      la = 64'(a >> (l * w));
      lb = 64'(b >> (l * w));
      r |= 256'(lane_op(op, sgn, la, lb, w)) << (l * w);
    end
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  always_comb ifc.in_alu_result = alu_chunk(ifc.out_alu_a, ifc.out_alu_b, ifc.out_alu_oper,
                                            ifc.out_alu_unsgn_or_sgn, ifc.out_alu_int_type);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns #1 after the accept edge with in_valid dropped.
  task automatic issue(input logic [255:0] a, input logic [255:0] b, input logic [3:0] op,
                       input logic sgn, input logic [1:0] ty, input logic sc);
    int cnt;
    ifc.in_a            = a;
    ifc.in_b            = b;
    ifc.in_oper         = op;
    ifc.in_unsgn_or_sgn = sgn;
    ifc.in_int_type     = ty;
    ifc.in_scalar       = sc;
    ifc.in_valid        = 1'b1;
    cnt = 0;
    while (!ifc.out_in_ready && cnt < 20) begin
      step();
      cnt++;
    end
    n_checks++;
    if (ifc.out_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_accept_timeout: out_in_ready=%b required 1", ifc.out_in_ready);
    end
    step();
    ifc.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if ({ifc.out_in_ready, ifc.out_valid, ifc.out_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags: ready/valid/busy=%b required 100",
               {ifc.out_in_ready, ifc.out_valid, ifc.out_busy});
    end
    n_checks++;
    if (ifc.out_data !== 256'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", ifc.out_data);
    end
    n_checks++;
    if ({ifc.out_alu_a, ifc.out_alu_b, ifc.out_alu_oper, ifc.out_alu_unsgn_or_sgn,
         ifc.out_alu_int_type} !== 135'd0) begin
      n_fail++;
      $display("FAIL reset_alu_outputs: a=%h b=%h oper=%h required all 0",
               ifc.out_alu_a, ifc.out_alu_b, ifc.out_alu_oper);
    end
  endtask

  task automatic test_vector_add();
    logic [255:0] a, b, req;
    a = {64'd4, 64'd3, 64'd2, 64'd1};
    b = {4{64'h10}};
    req = {64'h14, 64'h13, 64'h12, 64'h11};
    ifc.in_ready = 1'b1;
    issue(a, b, OpAdd, 1'b0, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ifc.out_alu_a !== 64'(i + 1) || ifc.out_valid !== 1'b0 || ifc.out_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL vadd_chunk%0d: alu_a=%h valid=%b busy=%b required %0d 0 1",
                 i, ifc.out_alu_a, ifc.out_valid, ifc.out_busy, i + 1);
      end
      step();
    end
    n_checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_data !== req) begin
      n_fail++;
      $display("FAIL vadd_result: valid=%b data=%h required 1 %h", ifc.out_valid, ifc.out_data,
               req);
    end
    step();
    n_checks++;
    if ({ifc.out_in_ready, ifc.out_valid, ifc.out_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL vadd_back_to_idle: ready/valid/busy=%b required 100",
               {ifc.out_in_ready, ifc.out_valid, ifc.out_busy});
    end
  endtask

  task automatic test_scalar_slt();
    logic [255:0] a, b;
    a = {rand256() | {192'd1, 64'd0}}; a[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
    b = {rand256() | {192'd1, 64'd0}}; b[63:0] = 64'd1;
    ifc.in_ready = 1'b1;
    issue(a, b, OpSlt, 1'b1, 2'd3, 1'b1);
    n_checks++;
    if (ifc.out_alu_unsgn_or_sgn !== 1'b1 || ifc.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sslt_run: sgn=%b valid=%b required 1 0", ifc.out_alu_unsgn_or_sgn,
               ifc.out_valid);
    end
    step();
    n_checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_data !== 256'h1) begin
      n_fail++;
      $display("FAIL sslt_result: valid=%b data=%h required 1 1", ifc.out_valid, ifc.out_data);
    end
    step();
    n_checks++;
    if (ifc.out_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sslt_back_to_idle: out_in_ready=%b required 1", ifc.out_in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] a1, b1, a2, b2, req1, held;
    logic stable;
    a1 = rand256(); b1 = rand256(); a2 = rand256(); b2 = rand256();
    req1 = exp_result(a1, b1, OpSub, 1'b0, 2'd1, 1'b0);
    ifc.in_ready = 1'b0;
    issue(a1, b1, OpSub, 1'b0, 2'd1, 1'b0);
    // Second request held pending for the whole stall.
    ifc.in_a = a2; ifc.in_b = b2; ifc.in_oper = OpXor; ifc.in_int_type = 2'd2;
    ifc.in_unsgn_or_sgn = 1'b0; ifc.in_scalar = 1'b0; ifc.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    held = ifc.out_data;
    n_checks++;
    if (ifc.out_valid !== 1'b1 || held !== req1) begin
      n_fail++;
      $display("FAIL bp_first_result: valid=%b data=%h required 1 %h", ifc.out_valid, held, req1);
    end
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ifc.out_valid !== 1'b1 || ifc.out_data !== held || ifc.out_in_ready !== 1'b0)
        stable = 1'b0;
    end
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall_stable: stable=%b required 1", stable);
    end
    ifc.in_ready = 1'b1;
    step();
    ifc.in_ready = 1'b0;
    n_checks++;
    if (ifc.out_in_ready !== 1'b1 || ifc.out_busy !== 1'b0 || ifc.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle_gap: ready/busy/valid=%b required 100",
               {ifc.out_in_ready, ifc.out_busy, ifc.out_valid});
    end
    step();
    ifc.in_valid = 1'b0;
    n_checks++;
    if (ifc.out_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second_accept: busy=%b required 1", ifc.out_busy);
    end
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (ifc.out_valid !== 1'b1 ||
        ifc.out_data !== exp_result(a2, b2, OpXor, 1'b0, 2'd2, 1'b0)) begin
      n_fail++;
      $display("FAIL bp_second_result: valid=%b data=%h required 1 %h", ifc.out_valid,
               ifc.out_data, exp_result(a2, b2, OpXor, 1'b0, 2'd2, 1'b0));
    end
    ifc.in_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_run();
    logic [255:0] a, b;
    logic seen;
    a = rand256(); b = rand256();
    ifc.in_ready = 1'b1;
    issue(a, b, OpAdd, 1'b0, 2'd0, 1'b0);
    step();
    step();
    rst = 1'b1;  // sampled on the edge where idx is 2
    step();
    rst = 1'b0;
    n_checks++;
    if ({ifc.out_in_ready, ifc.out_busy, ifc.out_valid} !== 3'b100 || ifc.out_data !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_run: ready/busy/valid=%b data=%h required 100 0",
               {ifc.out_in_ready, ifc.out_busy, ifc.out_valid}, ifc.out_data);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ifc.out_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_output: out_valid seen=%b required 0", seen);
    end
    a = rand256(); b = rand256();
    issue(a, b, OpAnd, 1'b0, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_data !== exp_result(a, b, OpAnd, 1'b0, 2'd2, 1'b0))
    begin
      n_fail++;
      $display("FAIL rst_fresh_op: valid=%b data=%h required 1 %h", ifc.out_valid, ifc.out_data,
               exp_result(a, b, OpAnd, 1'b0, 2'd2, 1'b0));
    end
    step();
  endtask

  task automatic test_operand_capture();
    logic [255:0] a, b, req;
    a = rand256(); b = rand256();
    req = exp_result(a, b, OpAdd, 1'b0, 2'd1, 1'b0);
    ifc.in_ready = 1'b1;
    issue(a, b, OpAdd, 1'b0, 2'd1, 1'b0);
    ifc.in_a = {256{1'b1}};
    ifc.in_oper = OpXor;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_data !== req) begin
      n_fail++;
      $display("FAIL capture_result: valid=%b data=%h required 1 %h", ifc.out_valid,
               ifc.out_data, req);
    end
    step();
  endtask

  task automatic test_random();
    logic [255:0] a, b, req, held;
    logic [3:0] op;
    logic sgn, sc, stable;
    logic [1:0] ty;
    int lat, dly;
    for (int t = 0; t < 24; t++) begin
      a = rand256(); b = rand256();
      op = 4'($urandom_range(0, 7));
      sgn = 1'($urandom_range(0, 1));
      ty = 2'($urandom_range(0, 3));
      sc = 1'($urandom_range(0, 1));
      dly = $urandom_range(0, 3);
      req = exp_result(a, b, op, sgn, ty, sc);
      ifc.in_ready = 1'b0;
      issue(a, b, op, sgn, ty, sc);
      ifc.in_valid = 1'b1;  // keep another request pending; it must not sneak in
      lat = 0;
      while (ifc.out_valid !== 1'b1 && lat < 10) begin
        step();
        lat++;
      end
      n_checks++;
      if (lat != (sc ? 1 : 4)) begin
        n_fail++;
        $display("FAIL rand%0d_latency: got %0d cycles required %0d", t, lat, sc ? 1 : 4);
      end
      held = ifc.out_data;
      n_checks++;
      if (held !== req) begin
        n_fail++;
        $display("FAIL rand%0d_data op=%0d sgn=%0d ty=%0d sc=%0d: got %h required %h",
                 t, op, sgn, ty, sc, held, req);
      end
      stable = 1'b1;
      for (int i = 0; i < dly; i++) begin
        step();
        if (ifc.out_valid !== 1'b1 || ifc.out_data !== held || ifc.out_in_ready !== 1'b0)
          stable = 1'b0;
      end
      ifc.in_valid = 1'b0;
      ifc.in_ready = 1'b1;
      step();
      n_checks++;
      if (stable !== 1'b1 || ifc.out_in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_handshake: stable=%b ready=%b valid=%b required 1 1 0",
                 t, stable, ifc.out_in_ready, ifc.out_valid);
      end
    end
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_ready = 1'b0;
    ifc.in_oper = '0;
    ifc.in_unsgn_or_sgn = 1'b0;
    ifc.in_int_type = '0;
    ifc.in_scalar = 1'b0;
    ifc.in_a = '0;
    ifc.in_b = '0;
    #1;
    test_reset();
    test_vector_add();
    test_scalar_slt();
    test_backpressure();
    test_reset_mid_run();
    test_operand_capture();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
